// File: rtl/sdrc_app_pkg.sv
// Shared types and constants for the SDRAM application-side responder.
//   app_state_e : responder FSM states
//   APP_ADDR_W  : width of the application word address
//   APP_LEN_W   : width of the burst length / beat counter
//   RD_LAT_W    : width of the read-latency down-counter
package sdrc_app_pkg;

    localparam int APP_ADDR_W = 30;
    localparam int APP_LEN_W  = 9;
    localparam int RD_LAT_W   = 4;

    typedef enum logic [2:0] {
        IDLE,
        ACK,
        WRITE,
        RD_WAIT,
        READ
    } app_state_e;

endpackage

// File: rtl/sdrc_app_mem.sv
// Single-port synchronous word RAM with per-byte active-low write enables
// and a registered read port. Only the read register is reset; the array
// contents are left untouched by reset.
//   clk      : clock
//   reset_n  : async active-low reset for the read data register
//   i_we     : write strobe
//   i_be_n   : active-low byte enables for the write
//   i_re     : read strobe; o_rdata holds its value when low
//   i_addr   : word index
//   i_wdata  : write data
//   o_rdata  : registered read data
module sdrc_app_mem #(
    parameter int DW = 32,
    parameter int AW = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            i_we,
    input  logic [DW/8-1:0] i_be_n,
    input  logic            i_re,
    input  logic [AW-1:0]   i_addr,
    input  logic [DW-1:0]   i_wdata,
    output logic [DW-1:0]   o_rdata
);

    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < DW/8; b++) begin
                if (!i_be_n[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sdrc_app_resp.sv
// Application-side stand-in for the SDRAM controller core. Accepts app_req
// bursts, acks them, consumes write beats and returns read beats from an
// internal byte-enabled RAM.
//   clk, reset_n                      : clock, async active-low reset
//   app_req/_addr/_len/_wr_n          : request channel
//   app_req_ack                       : one-cycle acceptance pulse
//   sdr_core_busy_n                   : high only while idle
//   app_wr_data/app_wr_en_n           : write beat data and byte enables
//   app_wr_next_req                   : write beat consumed this cycle
//   app_rd_valid/_data, app_last_rd   : read beat channel
module sdrc_app_resp
    import sdrc_app_pkg::*;
#(
    parameter int DW     = 32,
    parameter int AW     = 8,
    parameter int RD_LAT = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  app_req,
    input  logic [APP_ADDR_W-1:0] app_req_addr,
    input  logic [APP_LEN_W-1:0]  app_req_len,
    input  logic                  app_req_wr_n,
    output logic                  app_req_ack,
    output logic                  sdr_core_busy_n,
    input  logic [DW-1:0]         app_wr_data,
    input  logic [DW/8-1:0]       app_wr_en_n,
    output logic                  app_wr_next_req,
    output logic                  app_rd_valid,
    output logic [DW-1:0]         app_rd_data,
    output logic                  app_last_rd
);

    app_state_e            r_state, w_state_nxt;
    logic [AW-1:0]         r_base;
    logic [APP_LEN_W-1:0]  r_len;
    logic                  r_wr_n;
    logic [APP_LEN_W-1:0]  r_beat, w_beat_nxt;
    logic [RD_LAT_W-1:0]   r_cnt, w_cnt_nxt;
    logic                  r_ack, r_next, r_vld, r_last;
    logic                  w_latch, w_issue, w_mem_we, w_mem_re;
    logic                  w_vld_nxt, w_last_nxt;
    logic [AW-1:0]         w_mem_addr;
    logic                  w_unused;

    // Address bits above the RAM index are deliberately ignored.
    assign w_unused = &{1'b0, app_req_addr[APP_ADDR_W-1:AW]};

    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;
        w_issue     = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_re    = 1'b0;
        w_vld_nxt   = 1'b0;
        w_last_nxt  = 1'b0;
        w_mem_addr  = r_base + AW'(r_beat);

        case (r_state)
            IDLE: begin
                if (app_req) begin
                    w_latch     = 1'b1;
                    w_beat_nxt  = '0;
                    w_cnt_nxt   = RD_LAT_W'(RD_LAT - 1);
                    w_state_nxt = ACK;
                end
            end
            ACK: begin
                if (r_len == '0) begin
                    w_state_nxt = IDLE;
                end else if (!r_wr_n) begin
                    w_state_nxt = WRITE;
                end else if (r_cnt == '0) begin
                    // RD_LAT=1: the first read is issued straight out of ACK.
                    w_issue     = 1'b1;
                    w_state_nxt = READ;
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                    w_state_nxt = RD_WAIT;
                end
            end
            WRITE: begin
                w_mem_we   = 1'b1;
                w_beat_nxt = r_beat + 1'b1;
                if (r_beat == r_len - 1'b1) begin
                    w_state_nxt = IDLE;
                end
            end
            RD_WAIT: begin
                if (r_cnt == '0) begin
                    w_issue     = 1'b1;
                    w_state_nxt = READ;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            READ: begin
                // r_beat counts reads issued; the last one is on the bus now.
                if (r_beat == r_len) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_issue = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // A read issued on this edge appears on app_rd_data next cycle,
        // so valid/last are registered alongside it.
        if (w_issue) begin
            w_mem_re   = 1'b1;
            w_beat_nxt = r_beat + 1'b1;
            w_vld_nxt  = 1'b1;
            w_last_nxt = (r_beat == r_len - 1'b1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_beat  <= '0;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
            r_next  <= 1'b0;
            r_vld   <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ack   <= (w_state_nxt == ACK);
            r_next  <= (w_state_nxt == WRITE);
            r_vld   <= w_vld_nxt;
            r_last  <= w_last_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_latch) begin
            r_base <= app_req_addr[AW-1:0];
            r_len  <= app_req_len;
            r_wr_n <= app_req_wr_n;
        end
    end

    sdrc_app_mem #(
        .DW (DW),
        .AW (AW)
    ) u_mem (
        .clk     (clk),
        .reset_n (reset_n),
        .i_we    (w_mem_we),
        .i_be_n  (app_wr_en_n),
        .i_re    (w_mem_re),
        .i_addr  (w_mem_addr),
        .i_wdata (app_wr_data),
        .o_rdata (app_rd_data)
    );

    assign app_req_ack     = r_ack;
    assign app_wr_next_req = r_next;
    assign app_rd_valid    = r_vld;
    assign app_last_rd     = r_last;
    assign sdr_core_busy_n = (r_state == IDLE);

endmodule

// File: tb/tb_sdrc_app_resp.sv
module tb_sdrc_app_resp;

    localparam int RD_LAT = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        app_req;
    logic [29:0] app_req_addr;
    logic [8:0]  app_req_len;
    logic        app_req_wr_n;
    logic        app_req_ack;
    logic        sdr_core_busy_n;
    logic [31:0] app_wr_data;
    logic [3:0]  app_wr_en_n;
    logic        app_wr_next_req;
    logic        app_rd_valid;
    logic [31:0] app_rd_data;
    logic        app_last_rd;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [256];
    logic [31:0] wdata [16];
    logic [31:0] sb [$];

    always #5 clk = ~clk;

    sdrc_app_resp #(.DW(32), .AW(8), .RD_LAT(RD_LAT)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .app_req         (app_req),
        .app_req_addr    (app_req_addr),
        .app_req_len     (app_req_len),
        .app_req_wr_n    (app_req_wr_n),
        .app_req_ack     (app_req_ack),
        .sdr_core_busy_n (sdr_core_busy_n),
        .app_wr_data     (app_wr_data),
        .app_wr_en_n     (app_wr_en_n),
        .app_wr_next_req (app_wr_next_req),
        .app_rd_valid    (app_rd_valid),
        .app_rd_data     (app_rd_data),
        .app_last_rd     (app_last_rd)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    // All driving and sampling happens on falling edges.
    task automatic do_write(input logic [29:0] addr, input int len, input logic [3:0] be_n);
        logic [7:0] a;
        app_req_addr = addr;
        app_req_len  = 9'(len);
        app_req_wr_n = 1'b0;
        app_req      = 1'b1;
        @(negedge clk);
        checks++;
        if (app_req_ack !== 1'b1) begin
            errors++; $display("FAIL wr_ack: got %b want 1", app_req_ack);
        end
        app_req = 1'b0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            checks++;
            if (app_wr_next_req !== 1'b1 || (i == 0 && app_req_ack !== 1'b0)) begin
                errors++;
                $display("FAIL wr_next beat %0d: next=%b ack=%b want next=1 ack=0", i, app_wr_next_req, app_req_ack);
            end
            app_wr_data = wdata[i];
            app_wr_en_n = be_n;
            a = addr[7:0] + 8'(i);
            for (int b = 0; b < 4; b++) begin
                if (!be_n[b]) model[a][8*b +: 8] = wdata[i][8*b +: 8];
            end
        end
        @(negedge clk);
        checks++;
        if (app_wr_next_req !== 1'b0 || sdr_core_busy_n !== 1'b1) begin
            errors++;
            $display("FAIL wr_end: next=%b busy_n=%b want 0/1", app_wr_next_req, sdr_core_busy_n);
        end
        app_wr_en_n = 4'hF;
    endtask

    task automatic do_read(input logic [29:0] addr, input int len);
        int first;
        logic [31:0] exp;
        for (int i = 0; i < len; i++) sb.push_back(model[8'(addr[7:0] + 8'(i))]);
        app_req_addr = addr;
        app_req_len  = 9'(len);
        app_req_wr_n = 1'b1;
        app_req      = 1'b1;
        @(negedge clk);
        checks++;
        if (app_req_ack !== 1'b1) begin
            errors++; $display("FAIL rd_ack: got %b want 1", app_req_ack);
        end
        app_req = 1'b0;
        first = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (app_rd_valid === 1'b1) begin
                first = k;
                break;
            end
        end
        checks++;
        if (first != RD_LAT) begin
            errors++; $display("FAIL rd_latency: got %0d want %0d", first, RD_LAT);
        end
        if (first < 0) begin
            sb.delete();
            return;
        end
        for (int i = 0; i < len; i++) begin
            if (i > 0) @(negedge clk);
            exp = sb.pop_front();
            checks++;
            if (app_rd_valid !== 1'b1 || app_rd_data !== exp || app_last_rd !== (i == len - 1)) begin
                errors++;
                $display("FAIL rd_beat %0d: valid=%b data=%h last=%b want 1/%h/%b",
                         i, app_rd_valid, app_rd_data, app_last_rd, exp, (i == len - 1));
            end
        end
        @(negedge clk);
        checks++;
        if (app_rd_valid !== 1'b0 || app_last_rd !== 1'b0 || sdr_core_busy_n !== 1'b1) begin
            errors++;
            $display("FAIL rd_end: valid=%b last=%b busy_n=%b want 0/0/1", app_rd_valid, app_last_rd, sdr_core_busy_n);
        end
    endtask

    task automatic test_reset;
        checks++;
        if (app_req_ack !== 1'b0 || app_wr_next_req !== 1'b0 || app_rd_valid !== 1'b0 ||
            app_last_rd !== 1'b0 || app_rd_data !== 32'h0 || sdr_core_busy_n !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: ack=%b next=%b vld=%b last=%b data=%h busy_n=%b want 0/0/0/0/0/1",
                     app_req_ack, app_wr_next_req, app_rd_valid, app_last_rd, app_rd_data, sdr_core_busy_n);
        end
    endtask

    task automatic test_write_read;
        wdata[0] = 32'h11223344; wdata[1] = 32'h22334455; wdata[2] = 32'h33445566;
        wdata[3] = 32'h44556677; wdata[4] = 32'h55667788;
        do_write(30'h10000, 5, 4'h0);
        do_read(30'h10000, 5);
    endtask

    task automatic test_byte_mask;
        wdata[0] = 32'hFFFFFFFF;
        do_write(30'h20, 1, 4'h0);
        wdata[0] = 32'h00000000;
        do_write(30'h20, 1, 4'b1010);
        do_read(30'h20, 1);
    endtask

    task automatic test_wrap;
        for (int i = 0; i < 4; i++) wdata[i] = 32'(i + 1);
        do_write(30'h000000FE, 4, 4'h0);
        do_read(30'hFE, 2);
        do_read(30'h00, 2);
    endtask

    task automatic test_len0;
        int bad;
        app_req_addr = 30'h5;
        app_req_len  = 9'd0;
        app_req_wr_n = 1'b1;
        app_req      = 1'b1;
        @(negedge clk);
        checks++;
        if (app_req_ack !== 1'b1 || sdr_core_busy_n !== 1'b0) begin
            errors++; $display("FAIL len0_ack: ack=%b busy_n=%b want 1/0", app_req_ack, sdr_core_busy_n);
        end
        app_req = 1'b0;
        @(negedge clk);
        checks++;
        if (app_req_ack !== 1'b0 || sdr_core_busy_n !== 1'b1) begin
            errors++; $display("FAIL len0_idle: ack=%b busy_n=%b want 0/1", app_req_ack, sdr_core_busy_n);
        end
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (app_rd_valid !== 1'b0 || app_last_rd !== 1'b0 || app_req_ack !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL len0_quiet: %0d active cycles want 0", bad);
        end
    endtask

    task automatic test_reset_mid;
        int seen;
        app_req_addr = 30'h40;
        app_req_len  = 9'd8;
        app_req_wr_n = 1'b1;
        app_req      = 1'b1;
        @(negedge clk);
        app_req = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (app_rd_valid === 1'b1) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (seen == 0) begin
            errors++; $display("FAIL rstmid_start: no read beat seen want beat 0");
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if (app_req_ack !== 1'b0 || app_wr_next_req !== 1'b0 || app_rd_valid !== 1'b0 ||
            app_last_rd !== 1'b0 || app_rd_data !== 32'h0 || sdr_core_busy_n !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_async: ack=%b next=%b vld=%b last=%b data=%h busy_n=%b want 0/0/0/0/0/1",
                     app_req_ack, app_wr_next_req, app_rd_valid, app_last_rd, app_rd_data, sdr_core_busy_n);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        wdata[0] = 32'hCAFE0001; wdata[1] = 32'hCAFE0002;
        do_write(30'h50, 2, 4'h0);
        do_read(30'h50, 2);
    endtask

    task automatic test_held;
        int acks, beats, last_cyc, ack2_cyc;
        logic [31:0] exp;
        for (int i = 0; i < 2; i++) sb.push_back(model[8'h00 + 8'(i)]);
        for (int i = 0; i < 2; i++) sb.push_back(model[8'hFE + 8'(i)]);
        app_req_addr = 30'h10000;
        app_req_len  = 9'd2;
        app_req_wr_n = 1'b1;
        app_req      = 1'b1;
        @(negedge clk);
        checks++;
        if (app_req_ack !== 1'b1) begin
            errors++; $display("FAIL held_ack1: got %b want 1", app_req_ack);
        end
        app_req_addr = 30'hFE;
        acks = 1; beats = 0; last_cyc = -1; ack2_cyc = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (app_req_ack === 1'b1) begin
                acks++;
                if (acks == 2) begin
                    ack2_cyc = k;
                    app_req  = 1'b0;
                end
            end
            if (app_rd_valid === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL held_extra: unexpected beat data=%h", app_rd_data);
                end else begin
                    exp = sb.pop_front();
                    if (app_rd_data !== exp || app_last_rd !== (beats % 2 == 1)) begin
                        errors++;
                        $display("FAIL held_beat %0d: data=%h last=%b want %h/%b",
                                 beats, app_rd_data, app_last_rd, exp, (beats % 2 == 1));
                    end
                end
                if (app_last_rd === 1'b1 && last_cyc < 0) last_cyc = k;
                beats++;
                if (beats == 4) break;
            end
        end
        app_req = 1'b0;
        checks++;
        if (acks != 2 || beats != 4) begin
            errors++; $display("FAIL held_count: acks=%0d beats=%0d want 2/4", acks, beats);
        end
        checks++;
        if (last_cyc < 0 || ack2_cyc - last_cyc != 2) begin
            errors++; $display("FAIL held_gap: ack2-last=%0d want 2", ack2_cyc - last_cyc);
        end
        @(negedge clk);
        checks++;
        if (app_rd_valid !== 1'b0 || sdr_core_busy_n !== 1'b1) begin
            errors++; $display("FAIL held_end: valid=%b busy_n=%b want 0/1", app_rd_valid, sdr_core_busy_n);
        end
        sb.delete();
    endtask

    initial begin
        reset_n      = 1'b0;
        app_req      = 1'b0;
        app_req_addr = '0;
        app_req_len  = '0;
        app_req_wr_n = 1'b1;
        app_wr_data  = '0;
        app_wr_en_n  = 4'hF;
        repeat (3) @(negedge clk);
        test_reset;
        reset_n = 1'b1;
        @(negedge clk);
        test_write_read;
        test_byte_mask;
        test_wrap;
        test_len0;
        test_reset_mid;
        test_held;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sdrc_app_resp.md
Name: sdrc_app_resp

Overview:
Synthesizable responder for the SDRAM controller application request interface. It accepts app_req bursts, acknowledges them, and consumes write beats through app_wr_next_req. It returns read beats through app_rd_valid/app_last_rd from an internal byte-enabled word RAM. It is the drop-in stand-in for sdrc_core on the application side, used for FPGA bring-up of app-side masters and for cosimulating masters without the SDRAM model.

Parameters:
DW, 32, application data width in bits (multiple of 8).
AW, 8, RAM word-index bits; RAM depth 2**AW words.
RD_LAT, 3, cycles from app_req_ack pulse to first app_rd_valid (legal range 1..15).

Ports:
clk  in  1  system clock; all logic on rising edge.
reset_n  in  1  asynchronous active-low reset.
app_req  in  1  transfer request; held high until ack seen.
app_req_addr  in  30  word address; bits [AW-1:0] index the RAM, upper bits ignored.
app_req_len  in  9  burst length in DW words.
app_req_wr_n  in  1  0 = write, 1 = read.
app_req_ack  out  1  one-cycle pulse: request accepted.
sdr_core_busy_n  out  1  high only in IDLE.
app_wr_data  in  DW  write data, sampled on rising edges where app_wr_next_req=1.
app_wr_en_n  in  DW/8  active-low byte enables, sampled with app_wr_data.
app_wr_next_req  out  1  write beat consumed this cycle.
app_rd_valid  out  1  read data valid.
app_rd_data  out  DW  read data.
app_last_rd  out  1  high with the final read beat.

Behaviour:
- Reset: app_req_ack, app_wr_next_req, app_rd_valid, app_last_rd = 0; app_rd_data = 0; sdr_core_busy_n = 1; FSM = IDLE. RAM contents are not reset.
- Reset asserted mid-burst aborts the burst immediately. The partially written RAM keeps whatever beats already committed.
- FSM states: IDLE, ACK, WRITE, RD_WAIT, READ.
- IDLE:
  - On an edge with app_req=1, latch addr[AW-1:0], len and wr_n, then go to ACK.
  - app_req sampled in any other state is ignored.
- ACK:
  - Registered app_req_ack=1 for exactly one cycle; the first ack appears one cycle after app_req is sampled.
  - Next state: WRITE if wr_n=0; RD_WAIT if wr_n=1; IDLE if len=0.
  - A len=0 request is acked with no data phase.
- WRITE:
  - app_wr_next_req=1 on len consecutive cycles, starting the cycle after the ack pulse.
  - Each such edge writes RAM[(base+beat) mod 2**AW]. Only bytes with app_wr_en_n[b]=0 are updated.
  - After beat len-1, go to IDLE. next_req deasserts the following cycle.
- RD_WAIT:
  - A 4-bit down-counter loaded with RD_LAT-1 in ACK.
  - Go to READ when the counter reaches 0. The first app_rd_valid is exactly RD_LAT cycles after the ack cycle.
- READ:
  - app_rd_valid=1 for len consecutive cycles. app_rd_data = RAM[(base+beat) mod 2**AW], registered and aligned with valid.
  - app_last_rd=1 only on beat len-1, then IDLE.
  - Between beats, app_rd_data holds its last value.
- Beat counter is 9 bits and compares against latched len; len=511 is legal.
- Address arithmetic is AW bits and wraps modulo 2**AW; crossing the top of the RAM wraps to word 0 silently.
- Back-to-back: if app_req is still high on entry to IDLE, a new request is latched that edge. The minimum gap between bursts is 1 IDLE cycle.
- Read-after-write to the same address in consecutive bursts returns the new data; the RAM has write-first semantics across bursts.

Decomposition:
- Package sdrc_app_pkg:
  - typedef enum for the state (IDLE/ACK/WRITE/RD_WAIT/READ);
  - APP_ADDR_W=30 and APP_LEN_W=9 constants;
  - RD_LAT_W=4 counter width.
- One sub-module, sdrc_app_mem: single-port synchronous RAM with parameters DW and AW, registered read, and per-byte active-low write enables. The FSM top drives it.

Test Plan:
- Write then read: write len=5 at addr 0x10000 with data 11223344, 22334455, 33445566, 44556677, 55667788; then read len=5 at the same address.
  - Required: ack 1 cycle after req; five consecutive next_req pulses; first rd_valid RD_LAT=3 cycles after the read ack; data matches in order; last_rd only on beat 4.
- Byte mask: write 0xFFFFFFFF at addr 0x20, then write 0x00000000 with wr_en_n=4'b1010 at the same address; read back.
  - Required: 0xFF00FF00.
- Wrap: write len=4 at addr 0x000000FE (AW=8) with data 1..4.
  - Required: reads of len=2 at 0xFE and at 0x00 return 1,2 and 3,4 respectively.
- len=0: a read request with len=0.
  - Required: a single ack; no rd_valid or last_rd for 20 cycles; sdr_core_busy_n returns to 1 after 2 cycles.
- Reset mid-burst: assert reset_n=0 during beat 2 of a len=8 read.
  - Required: all outputs 0 and busy_n=1 asynchronously. A new write/read of len=2 afterwards completes normally.
- Held request: keep app_req=1 across two reads.
  - Required: exactly one ack per burst, and the second ack arrives 2 cycles after the first burst's last_rd.
